qei_decoder_param: RTL and testbench
====================================

Name: qei_decoder_param

Overview:
Parametrised successor to the single-channel X4 quadrature counter. It adds the following over the fixed-width counter:
- configurable counter width and input synchroniser depth
- a per-input digital glitch filter
- selectable X1/X2/X4 decoding and direction inversion
- an index input with position latch and optional zeroing
- sticky illegal-transition detection
- a windowed velocity measurement

The block sits between the encoder pins and the pin-mapping top level, which slices count/dir/status onto uo_out/uio_out.

Parameters:
CNT_W, 16, position counter width (>=8)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILT_LEN, 4, consecutive stable cycles required before a filtered input changes (>=1; 1 = no filtering, single register)
VEL_W, 16, width of velocity window counter and signed velocity result

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
enc_a  input  1  encoder channel A, asynchronous
enc_b  input  1  encoder channel B, asynchronous
enc_idx  input  1  encoder index, asynchronous, active-high
mode  input  2  00=X4, 01=X2, 10=X1, 11=X4
invert_dir  input  1  1 = negate every step
idx_clear_en  input  1  1 = rising index edge zeroes count
cnt_load  input  1  1-cycle strobe, load count
cnt_load_val  input  CNT_W  load value
status_clr  input  1  clears err and idx_seen
vel_period  input  VEL_W  velocity window length in cycles; 0 = disabled
count  output  CNT_W  position, unsigned, wraps
dir  output  1  direction of last counted step (1 = up)
step  output  1  1-cycle pulse when count changed due to the encoder
err  output  1  sticky illegal-transition flag
idx_latch  output  CNT_W  count captured at last index edge
idx_seen  output  1  sticky: index edge occurred
vel  output  VEL_W  signed net steps in last completed window
vel_valid  output  1  1-cycle pulse when vel updates

Behaviour:
- Reset: all synchroniser, filter and prev-state registers go to 0, and so do all outputs (count, dir, step, err, idx_latch, idx_seen, vel, vel_valid, window counter, accumulator). A reset mid-operation aborts everything, including the velocity window.
- Sync:
  - a, b and idx each pass through SYNC_STAGES flops.
  - Filter: a per-input counter runs while sync != filt.
  - filt takes the sync value on the FILT_LEN-th consecutive differing cycle.
  - Any cycle with sync == filt resets the counter.
- Decode: prev <= {filt_a, filt_b} every cycle. On a transition (prev != cur):
  - Forward: 00->01->11->10->00. Backward: the reverse.
  - Both bits changing is illegal: err <= 1, no count, and prev still updates.
  - X4: every legal transition counts ±1.
  - X2: only transitions where A changes count. +1 on 01->11 and 10->00; -1 on 11->01 and 00->10.
  - X1: +1 on 01->11 only; -1 on 11->01 only.
  - invert_dir negates the step sign.
- Latency: an enc_a/enc_b level change that is stable for FILT_LEN+SYNC_STAGES cycles updates count exactly SYNC_STAGES+FILT_LEN+1 clock edges after the first edge sampling the new level. With the defaults this is 7 cycles.
- Count update priority: rst > cnt_load > index clear > encoder step.
  - cnt_load: count <= cnt_load_val on the next edge; a same-cycle step is discarded and step stays 0.
  - Encoder step: count wraps modulo 2^CNT_W in both directions.
  - dir updates only on a counted step and holds otherwise.
  - step pulses only when an encoder step is applied.
- Index (filtered rising edge):
  - idx_latch <= count as it stands pre-update in that cycle.
  - idx_seen <= 1.
  - If idx_clear_en, count <= 0 and any same-cycle step is discarded.
  - cnt_load still wins over the index clear; idx_latch and idx_seen still update in that case.
- status_clr clears err and idx_seen. A set event in the same cycle wins.
- Velocity:
  - The window counter runs 0..vel_period-1 starting at reset release.
  - The accumulator sums applied signed steps; load and index-clear cycles contribute 0.
  - On the terminal cycle: vel <= accumulator plus this cycle's step, saturated to the signed VEL_W range. vel_valid pulses for 1 cycle, and the accumulator and window counter restart at 0.
  - If vel_period changes so that the window counter is >= vel_period, the terminal condition fires on the next cycle.
  - vel_period=0: window counter and accumulator held at 0, vel holds, no vel_valid.
- mode and invert_dir changes take effect on the next transition; the count is not altered.

Test Plan:
1. Defaults, X4, after reset+32 idle cycles: 8 forward cycles (4 states each, 16 cycles per state) -> count=32, dir=1, 32 step pulses, err=0.
2. From count=32: 64 backward cycles -> count=0xFF20 (wrap), dir=0; then 64 forward cycles -> count=0x0020.
3. mode=10 (X1): 4 forward cycles -> +4. mode=01 (X2): 4 forward cycles -> +8. invert_dir=1 in X4: 1 forward cycle -> -4.
4. Illegal 00->11 held 16 cycles -> err=1, count unchanged. A 3-cycle glitch on A with FILT_LEN=4 -> no step and no err. status_clr -> err=0.
5. count=100, idx_clear_en=1, idx pulse for 16 cycles -> idx_latch=100, count=0, idx_seen=1. cnt_load with 0x1234 during an active step -> count=0x1234, step=0.
6. vel_period=1000: forward steps every 16 cycles from reset release for 640 cycles, then hold -> first vel_valid at cycle 1000 with vel=40. Next window with no steps -> vel=0.

Source files
------------

// File: rtl/qei_decoder_param.sv
// Quadrature encoder decoder: synchronised and glitch-filtered A/B/index inputs,
// X1/X2/X4 decode, index latch/zeroing, sticky error flag and windowed velocity.
module qei_decoder_param #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int VEL_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               enc_idx,
  input  logic [1:0]         mode,
  input  logic               invert_dir,
  input  logic               idx_clear_en,
  input  logic               cnt_load,
  input  logic [CNT_W-1:0]   cnt_load_val,
  input  logic               status_clr,
  input  logic [VEL_W-1:0]   vel_period,
  output logic [CNT_W-1:0]   count,
  output logic               dir,
  output logic               step,
  output logic               err,
  output logic [CNT_W-1:0]   idx_latch,
  output logic               idx_seen,
  output logic [VEL_W-1:0]   vel,
  output logic               vel_valid
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

  // Signed sum saturated to the VEL_W two's-complement range.
  function automatic logic [VEL_W-1:0] sat_vel(input logic [VEL_W:0] s);
    logic [VEL_W-1:0] r;
    if (s[VEL_W] != s[VEL_W-1]) begin
      r = s[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
    end else begin
      r = s[VEL_W-1:0];
    end
    return r;
  endfunction

  logic [2:0]                    raw_s;
  logic [2:0][SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [2:0][FCW-1:0]           fcnt_q, fcnt_d;
  logic [2:0]                    filt_q, filt_d;
  logic [1:0]                    prev_q, prev_d;
  logic                          idx_prev_q, idx_prev_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          dir_q, dir_d;
  logic                          step_q, step_d;
  logic                          err_q, err_d;
  logic [CNT_W-1:0]              idx_latch_q, idx_latch_d;
  logic                          idx_seen_q, idx_seen_d;
  logic [VEL_W-1:0]              win_q, win_d;
  logic [VEL_W:0]                acc_q, acc_d;
  logic [VEL_W-1:0]              vel_q, vel_d;
  logic                          vel_valid_q, vel_valid_d;

  logic [1:0]     cur_s;
  logic [1:0]     trans_s;
  logic           illegal_s;
  logic           legal_s;
  logic           fwd_s;
  logic           cnt_en_s;
  logic           up_s;
  logic           idx_rise_s;
  logic [VEL_W:0] delta_s;
  logic [VEL_W:0] sum_s;

  // Bit order: 0 = B, 1 = A, 2 = index.
  assign raw_s = {enc_idx, enc_a, enc_b};

  // Synchroniser shift and per-input stability filter.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_s[i]};
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync_q[i][SYNC_STAGES-1];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCW'(1);
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  // Transition classification and mode qualification.
  always_comb begin
    cur_s     = filt_q[1:0];
    trans_s   = prev_q ^ cur_s;
    illegal_s = (trans_s == 2'b11);
    legal_s   = (trans_s != 2'b00) && !illegal_s;
    case ({prev_q, cur_s})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd_s = 1'b1;
      default:                            fwd_s = 1'b0;
    endcase
    case (mode)
      2'b01:   cnt_en_s = legal_s && trans_s[1];
      2'b10:   cnt_en_s = legal_s && (({prev_q, cur_s} == 4'b0111) || ({prev_q, cur_s} == 4'b1101));
      default: cnt_en_s = legal_s;
    endcase
    up_s       = fwd_s ^ invert_dir;
    idx_rise_s = filt_q[2] & ~idx_prev_q;
  end

  // Count, direction, status and index bookkeeping.
  always_comb begin
    prev_d      = cur_s;
    idx_prev_d  = filt_q[2];
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    delta_s     = '0;
    if (cnt_load) begin
      cnt_d = cnt_load_val;
    end else if (idx_rise_s && idx_clear_en) begin
      cnt_d = '0;
    end else if (cnt_en_s) begin
      cnt_d   = up_s ? (cnt_q + CNT_W'(1)) : (cnt_q - CNT_W'(1));
      dir_d   = up_s;
      step_d  = 1'b1;
      delta_s = up_s ? {{VEL_W{1'b0}}, 1'b1} : {(VEL_W+1){1'b1}};
    end else begin
      cnt_d = cnt_q;
    end
    if (illegal_s) begin
      err_d = 1'b1;
    end else if (status_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (idx_rise_s) begin
      idx_latch_d = cnt_q;
      idx_seen_d  = 1'b1;
    end else begin
      idx_latch_d = idx_latch_q;
      idx_seen_d  = status_clr ? 1'b0 : idx_seen_q;
    end
  end

  // Velocity window; a shrunken period makes the >= test fire promptly.
  always_comb begin
    sum_s       = acc_q + delta_s;
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    if (vel_period == '0) begin
      win_d = '0;
      acc_d = '0;
    end else if (win_q >= (vel_period - VEL_W'(1))) begin
      vel_d       = sat_vel(sum_s);
      vel_valid_d = 1'b1;
      win_d       = '0;
      acc_d       = '0;
    end else begin
      win_d = win_q + VEL_W'(1);
      acc_d = sum_s;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      fcnt_q      <= '0;
      filt_q      <= '0;
      prev_q      <= '0;
      idx_prev_q  <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      idx_latch_q <= '0;
      idx_seen_q  <= 1'b0;
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fcnt_q      <= fcnt_d;
      filt_q      <= filt_d;
      prev_q      <= prev_d;
      idx_prev_q  <= idx_prev_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      idx_latch_q <= idx_latch_d;
      idx_seen_q  <= idx_seen_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign count     = cnt_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign err       = err_q;
  assign idx_latch = idx_latch_q;
  assign idx_seen  = idx_seen_q;
  assign vel       = vel_q;
  assign vel_valid = vel_valid_q;

endmodule

// File: tb/tb_qei_decoder_param.sv
// Directed bench for qei_decoder_param with default parameters.
module tb_qei_decoder_param;

  logic        clk;
  logic        rst;
  logic        enc_a;
  logic        enc_b;
  logic        enc_idx;
  logic [1:0]  mode;
  logic        invert_dir;
  logic        idx_clear_en;
  logic        cnt_load;
  logic [15:0] cnt_load_val;
  logic        status_clr;
  logic [15:0] vel_period;
  logic [15:0] count;
  logic        dir;
  logic        step;
  logic        err;
  logic [15:0] idx_latch;
  logic        idx_seen;
  logic [15:0] vel;
  logic        vel_valid;

  int n_checks;
  int n_fail;
  int step_cnt;
  int vv_cnt;
  int step_base;

  qei_decoder_param dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_idx(enc_idx),
    .mode(mode), .invert_dir(invert_dir), .idx_clear_en(idx_clear_en),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .status_clr(status_clr),
    .vel_period(vel_period), .count(count), .dir(dir), .step(step), .err(err),
    .idx_latch(idx_latch), .idx_seen(idx_seen), .vel(vel), .vel_valid(vel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters read the pre-edge output values.
  always @(posedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (vel_valid === 1'b1) vv_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] v);
    enc_a = v[1];
    enc_b = v[0];
    hold(16);
  endtask

  task automatic fwd_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
    end
  endtask

  task automatic bwd_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
    end
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    hold(1);
    status_clr = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; step_cnt = 0; vv_cnt = 0;
    rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_idx = 1'b0; mode = 2'b00;
    invert_dir = 1'b0; idx_clear_en = 1'b0; cnt_load = 1'b0; cnt_load_val = 16'h0000;
    status_clr = 1'b0; vel_period = 16'd0;
    hold(3);
    check_val("rst_count", 32'(count), 32'h0);
    check_val("rst_dir", 32'(dir), 32'h0);
    check_val("rst_step", 32'(step), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    check_val("rst_idx", 32'({idx_seen, idx_latch}), 32'h0);
    check_val("rst_vel", 32'({vel_valid, vel}), 32'h0);
    rst = 1'b0;
    hold(32);

    // X4 forward, first transition timed to the edge
    enc_a = 1'b0; enc_b = 1'b1;
    hold(6);
    check_val("lat_before", 32'(count), 32'h0);
    hold(1);
    check_val("lat_at7", 32'(count), 32'h1);
    hold(9);
    set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
    fwd_cycles(7);
    check_val("x4_fwd_count", 32'(count), 32'h20);
    check_val("x4_fwd_dir", 32'(dir), 32'h1);
    check_val("x4_fwd_steps", 32'(step_cnt), 32'd32);
    check_val("x4_fwd_err", 32'(err), 32'h0);

    bwd_cycles(64);
    check_val("x4_bwd_wrap", 32'(count), 32'hFF20);
    check_val("x4_bwd_dir", 32'(dir), 32'h0);
    fwd_cycles(64);
    check_val("x4_fwd_wrap", 32'(count), 32'h0020);
    check_val("x4_fwd_dir2", 32'(dir), 32'h1);

    mode = 2'b10;
    step_base = step_cnt;
    fwd_cycles(4);
    check_val("x1_count", 32'(count), 32'h24);
    check_val("x1_steps", 32'(step_cnt - step_base), 32'd4);
    mode = 2'b01;
    fwd_cycles(4);
    check_val("x2_count", 32'(count), 32'h2C);
    mode = 2'b00;
    invert_dir = 1'b1;
    fwd_cycles(1);
    check_val("inv_count", 32'(count), 32'h28);
    check_val("inv_dir", 32'(dir), 32'h0);
    invert_dir = 1'b0;

    // Illegal jump, glitch rejection, status clear
    step_base = step_cnt;
    set_ab(2'b11);
    check_val("ill_err", 32'(err), 32'h1);
    check_val("ill_count", 32'(count), 32'h28);
    set_ab(2'b00);
    pulse_clr();
    check_val("clr_err", 32'(err), 32'h0);
    enc_a = 1'b1;
    hold(3);
    enc_a = 1'b0;
    hold(16);
    check_val("glitch_count", 32'(count), 32'h28);
    check_val("glitch_err", 32'(err), 32'h0);
    check_val("glitch_steps", 32'(step_cnt - step_base), 32'd0);

    // Index latch and zeroing
    cnt_load_val = 16'd100; cnt_load = 1'b1;
    hold(1);
    cnt_load = 1'b0;
    check_val("load100", 32'(count), 32'd100);
    idx_clear_en = 1'b1;
    enc_idx = 1'b1;
    hold(16);
    enc_idx = 1'b0;
    hold(16);
    check_val("idx_latch", 32'(idx_latch), 32'd100);
    check_val("idx_zero", 32'(count), 32'h0);
    check_val("idx_seen", 32'(idx_seen), 32'h1);

    // Load beats a same-edge encoder step
    step_base = step_cnt;
    enc_a = 1'b0; enc_b = 1'b1;
    hold(6);
    cnt_load_val = 16'h1234; cnt_load = 1'b1;
    hold(1);
    cnt_load = 1'b0;
    check_val("load_step_count", 32'(count), 32'h1234);
    check_val("load_step_pulse", 32'(step), 32'h0);
    hold(9);
    check_val("load_hold", 32'(count), 32'h1234);
    check_val("load_no_steps", 32'(step_cnt - step_base), 32'd0);
    pulse_clr();
    check_val("clr_idx_seen", 32'(idx_seen), 32'h0);
    check_val("vel_off", 32'(vv_cnt), 32'd0);

    // Velocity window from reset release
    idx_clear_en = 1'b0;
    set_ab(2'b00);
    rst = 1'b1; vel_period = 16'd1000;
    hold(2);
    check_val("midrst_count", 32'(count), 32'h0);
    rst = 1'b0;
    fwd_cycles(10);
    check_val("vel_count", 32'(count), 32'd40);
    hold(359);
    check_val("vv_early", 32'(vel_valid), 32'h0);
    hold(1);
    check_val("vv_1000", 32'(vel_valid), 32'h1);
    check_val("vel_40", 32'(vel), 32'd40);
    hold(1);
    check_val("vv_pulse", 32'(vel_valid), 32'h0);
    hold(998);
    check_val("vel_hold", 32'({vel_valid, vel}), 32'd40);
    hold(1);
    check_val("vv_2000", 32'(vel_valid), 32'h1);
    check_val("vel_0", 32'(vel), 32'd0);
    hold(2);
    check_val("vv_total", 32'(vv_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
